pcie_rd_arbiter: RTL and testbench

Shares one AXI4 read channel (AR + R) of the PCIe host interface between NREQ independent read requesters. Requests are granted in round-robin order, then forwarded to the PCIe slave. Returning R beats are routed back to the requester that issued each burst, in issue order, using an internal route FIFO of grant indices. Sits between DMA read engines and the PCIe slave (or its simulation model).

---
 rtl/pcie_rd_arbiter_pkg.sv | 24 ++
 rtl/pcie_rd_arbiter_route_fifo.sv | 52 +++++
 rtl/pcie_rd_arbiter.sv | 150 +++++++++++++++
 tb/tb_pcie_rd_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_rd_arbiter_pkg.sv
// Shared constants, AR FSM encoding and helpers for the PCIe read-channel arbiter.
package pcie_rd_arbiter_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic {
    AR_IDLE  = 1'b0,
    AR_ISSUE = 1'b1
  } ar_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pcie_rd_arbiter_route_fifo.sv
// Route FIFO of grant indices: one entry per outstanding burst, popped on RLAST.
module rd_route_fifo
  import pcie_rd_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IW    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic [IW-1:0]           push_data,
  input  logic                    pop,
  output logic [IW-1:0]           head,
  output logic                    full,
  output logic                    empty,
  output logic [clog2(DEPTH):0]   count
);

  localparam int unsigned PW = clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [IW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage carries no reset; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/pcie_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read channel among NREQ requesters,
// routing R beats back to the issuing requester in issue order.
module pcie_rd_arbiter
  import pcie_rd_arbiter_pkg::*;
#(
  parameter int unsigned DW    = 512,
  parameter int unsigned AW    = 64,
  parameter int unsigned NREQ  = 2,
  parameter int unsigned DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ*AW-1:0]   req_araddr,
  input  logic [NREQ*8-1:0]    req_arlen,
  input  logic [NREQ-1:0]      req_arvalid,
  output logic [NREQ-1:0]      req_arready,
  output logic [DW-1:0]        req_rdata,
  output logic                 req_rlast,
  output logic [1:0]           req_rresp,
  output logic [NREQ-1:0]      req_rvalid,
  input  logic [NREQ-1:0]      req_rready,
  output logic [AW-1:0]        M_AXI_ARADDR,
  output logic [7:0]           M_AXI_ARLEN,
  output logic [2:0]           M_AXI_ARSIZE,
  output logic [1:0]           M_AXI_ARBURST,
  output logic [3:0]           M_AXI_ARID,
  output logic                 M_AXI_ARVALID,
  input  logic                 M_AXI_ARREADY,
  input  logic [DW-1:0]        M_AXI_RDATA,
  input  logic [1:0]           M_AXI_RRESP,
  input  logic                 M_AXI_RLAST,
  input  logic                 M_AXI_RVALID,
  output logic                 M_AXI_RREADY
);

  localparam int unsigned IW = clog2(NREQ);
  localparam int unsigned CW = clog2(DEPTH) + 1;

  ar_state_e      state;
  ar_state_e      state_next;
  logic [IW-1:0]  rr_ptr;
  logic [IW-1:0]  grant;
  logic [IW-1:0]  sel_idx;
  logic           sel_found;
  logic           grant_take;
  logic [AW-1:0]  addr_q;
  logic [7:0]     len_q;

  logic           fifo_push;
  logic           fifo_pop;
  logic           fifo_full;
  logic           fifo_empty;
  logic [IW-1:0]  fifo_head;
  logic [CW-1:0]  fifo_count_unused;
  logic           route_valid;

  // First asserted requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    sel_found = 1'b0;
    sel_idx   = rr_ptr;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(rr_ptr) + k) % NREQ;
      if (!sel_found && req_arvalid[IW'(idx)]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(idx);
      end
    end
  end

  always_comb begin
    state_next    = state;
    req_arready   = '0;
    grant_take    = 1'b0;
    fifo_push     = 1'b0;
    M_AXI_ARVALID = 1'b0;
    case (state)
      AR_IDLE: begin
        if (sel_found && !fifo_full) begin
          req_arready[sel_idx] = 1'b1;
          grant_take           = 1'b1;
          state_next           = AR_ISSUE;
        end
      end
      AR_ISSUE: begin
        M_AXI_ARVALID = 1'b1;
        if (M_AXI_ARREADY) begin
          fifo_push  = 1'b1;
          state_next = AR_IDLE;
        end
      end
      default: state_next = AR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= AR_IDLE;
      rr_ptr <= '0;
      grant  <= '0;
      addr_q <= '0;
      len_q  <= '0;
    end else begin
      state <= state_next;
      if (grant_take) begin
        grant  <= sel_idx;
        addr_q <= req_araddr[int'(sel_idx)*AW +: AW];
        len_q  <= req_arlen[int'(sel_idx)*8 +: 8];
      end
      if (fifo_push) rr_ptr <= (grant == IW'(NREQ-1)) ? '0 : grant + IW'(1);
    end
  end

  rd_route_fifo #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_route_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (grant),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count_unused)
  );

  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARLEN   = len_q;
  assign M_AXI_ARSIZE  = 3'(clog2(DW/8));
  assign M_AXI_ARBURST = BURST_INCR;
  assign M_AXI_ARID    = 4'd0;

  // R path: the FIFO head owns the channel; nothing is accepted while empty.
  assign route_valid  = !fifo_empty;
  assign M_AXI_RREADY = route_valid && req_rready[fifo_head];
  assign fifo_pop     = route_valid && M_AXI_RVALID && M_AXI_RREADY && M_AXI_RLAST;

  always_comb begin
    req_rvalid = '0;
    if (route_valid) req_rvalid[fifo_head] = M_AXI_RVALID;
  end

  assign req_rdata = M_AXI_RDATA;
  assign req_rlast = M_AXI_RLAST;
  assign req_rresp = M_AXI_RRESP;

endmodule

// File: tb/tb_pcie_rd_arbiter.sv
// Randomized directed bench for pcie_rd_arbiter against a queue-based reference model.
module tb_pcie_rd_arbiter;
  import pcie_rd_arbiter_pkg::*;

  localparam int unsigned DW    = 512;
  localparam int unsigned AW    = 64;
  localparam int unsigned NREQ  = 3;
  localparam int unsigned DEPTH = 16;

  logic               clk;
  logic               reset;
  logic [NREQ*AW-1:0] req_araddr;
  logic [NREQ*8-1:0]  req_arlen;
  logic [NREQ-1:0]    req_arvalid;
  logic [NREQ-1:0]    req_arready;
  logic [DW-1:0]      req_rdata;
  logic               req_rlast;
  logic [1:0]         req_rresp;
  logic [NREQ-1:0]    req_rvalid;
  logic [NREQ-1:0]    req_rready;
  logic [AW-1:0]      M_AXI_ARADDR;
  logic [7:0]         M_AXI_ARLEN;
  logic [2:0]         M_AXI_ARSIZE;
  logic [1:0]         M_AXI_ARBURST;
  logic [3:0]         M_AXI_ARID;
  logic               M_AXI_ARVALID;
  logic               M_AXI_ARREADY;
  logic [DW-1:0]      M_AXI_RDATA;
  logic [1:0]         M_AXI_RRESP;
  logic               M_AXI_RLAST;
  logic               M_AXI_RVALID;
  logic               M_AXI_RREADY;

  pcie_rd_arbiter #(
    .DW(DW), .AW(AW), .NREQ(NREQ), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .req_araddr(req_araddr), .req_arlen(req_arlen),
    .req_arvalid(req_arvalid), .req_arready(req_arready),
    .req_rdata(req_rdata), .req_rlast(req_rlast), .req_rresp(req_rresp),
    .req_rvalid(req_rvalid), .req_rready(req_rready),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
    .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST),
    .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests  = 0;
  int fails  = 0;
  int q_req[$];
  int q_len[$];
  int beat   = 0;
  int rr_exp = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] onehot(input int i);
    return NREQ'(1) << i;
  endfunction

  // Round-robin rule: first active requester at or after the pointer, wrapping.
  function automatic int model_pick(input logic [NREQ-1:0] act);
    for (int k = 0; k < NREQ; k++)
      if (act[(rr_exp + k) % NREQ]) return (rr_exp + k) % NREQ;
    return -1;
  endfunction

  function automatic int remaining_beats();
    int n = 0;
    foreach (q_len[i]) n += q_len[i] + 1;
    return n - beat;
  endfunction

  // One arbitration: requesters in 'active' raise arvalid, the winner is issued
  // after 'stall' cycles of ARREADY low. flen<0 randomizes lengths.
  task automatic arb_cycle(input logic [NREQ-1:0] active, input int stall,
                           input int flen, input logic [AW-1:0] faddr);
    logic [AW-1:0] a [NREQ];
    int            l [NREQ];
    int            g;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      a[i] = {$urandom, $urandom};
      l[i] = int'($urandom_range(0, 7));
      if (flen >= 0) l[i] = flen;
      if (faddr != '0) a[i] = faddr;
      req_araddr[i*AW +: AW] = a[i];
      req_arlen[i*8 +: 8]    = 8'(l[i]);
    end
    req_arvalid   = active;
    M_AXI_ARREADY = 1'b0;
    g = model_pick(active);
    #1;
    check("ar_grant", DW'(req_arready), DW'(onehot(g)));
    check("ar_valid_latch_cycle", DW'(M_AXI_ARVALID), DW'(1'b0));
    for (int s = 0; s <= stall; s++) begin
      @(negedge clk);
      req_arvalid[g] = 1'b0;
      M_AXI_ARREADY  = (s == stall);
      #1;
      check("ar_valid", DW'(M_AXI_ARVALID), DW'(1'b1));
      check("ar_addr", DW'(M_AXI_ARADDR), DW'(a[g]));
      check("ar_len", DW'(M_AXI_ARLEN), DW'(8'(l[g])));
      check("ar_size", DW'(M_AXI_ARSIZE), DW'(3'd6));
      check("ar_burst_id", DW'({M_AXI_ARBURST, M_AXI_ARID}), DW'({2'b01, 4'd0}));
      check("ar_no_pulse_in_issue", DW'(req_arready), DW'(0));
    end
    @(posedge clk);
    #1;
    req_arvalid   = '0;
    M_AXI_ARREADY = 1'b0;
    q_req.push_back(g);
    q_len.push_back(l[g]);
    rr_exp = (g + 1) % NREQ;
  endtask

  // Slave returns 'nbeats' beats in model order; owner's rready is held low
  // for the first 'hold' cycles while every other requester is ready.
  task automatic drain_beats(input int nbeats, input int hold);
    int              done = 0;
    int              cyc  = 0;
    int              h;
    logic            last;
    logic            rv;
    logic [DW-1:0]   d;
    logic [1:0]      rs;
    logic [NREQ-1:0] rr;
    while (done < nbeats && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      h    = q_req[0];
      last = (beat == q_len[0]);
      rv   = ($urandom_range(0, 3) != 0);
      for (int w = 0; w < int'(DW/32); w++) d[w*32 +: 32] = $urandom;
      rs = ($urandom_range(0, 1) != 0) ? RESP_OKAY : 2'($urandom);
      rr = NREQ'($urandom);
      if (cyc <= hold) begin
        rr    = '1;
        rr[h] = 1'b0;
      end else begin
        rr[h] = ($urandom_range(0, 3) != 0);
      end
      M_AXI_RVALID = rv;
      M_AXI_RDATA  = d;
      M_AXI_RRESP  = rs;
      M_AXI_RLAST  = last;
      req_rready   = rr;
      #1;
      check("r_valid_route", DW'(req_rvalid), DW'(rv ? onehot(h) : NREQ'(0)));
      check("r_ready_route", DW'(M_AXI_RREADY), DW'(rr[h]));
      check("r_data", req_rdata, d);
      check("r_last", DW'(req_rlast), DW'(last));
      check("r_resp", DW'(req_rresp), DW'(rs));
      if (rv && rr[h]) begin
        done++;
        if (last) begin
          void'(q_req.pop_front());
          void'(q_len.pop_front());
          beat = 0;
        end else begin
          beat++;
        end
      end
    end
    check("r_beat_budget", DW'(done), DW'(nbeats));
    @(posedge clk);
    #1;
    M_AXI_RVALID = 1'b0;
    M_AXI_RLAST  = 1'b0;
    req_rready   = '0;
  endtask

  // With nothing outstanding, stray beats must be neither routed nor accepted.
  task automatic idle_r_check();
    @(negedge clk);
    M_AXI_RVALID = 1'b1;
    M_AXI_RLAST  = 1'b1;
    req_rready   = '1;
    #1;
    check("idle_rvalid", DW'(req_rvalid), DW'(0));
    check("idle_rready", DW'(M_AXI_RREADY), DW'(1'b0));
    @(negedge clk);
    M_AXI_RVALID = 1'b0;
    M_AXI_RLAST  = 1'b0;
    req_rready   = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    req_araddr    = '0;
    req_arlen     = '0;
    req_arvalid   = '0;
    req_rready    = '0;
    M_AXI_ARREADY = 1'b0;
    M_AXI_RDATA   = '0;
    M_AXI_RRESP   = '0;
    M_AXI_RLAST   = 1'b0;
    M_AXI_RVALID  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_arvalid", DW'(M_AXI_ARVALID), DW'(1'b0));
    check("rst_arready", DW'(req_arready), DW'(0));
    check("rst_rvalid", DW'(req_rvalid), DW'(0));
    check("rst_rready", DW'(M_AXI_RREADY), DW'(1'b0));
    @(negedge clk);
    reset = 1'b0;
    idle_r_check();

    // Single request from requester 0.
    arb_cycle(3'b001, 0, 3, 64'h1000);
    drain_beats(4, 0);
    idle_r_check();

    // Round-robin with all three, then two, requesters contending.
    repeat (6) arb_cycle(3'b111, 0, -1, '0);
    repeat (4) arb_cycle(3'b011, 0, -1, '0);
    drain_beats(remaining_beats(), 0);

    // Owner not ready: the long burst blocks the short one behind it.
    arb_cycle(3'b001, 0, 7, '0);
    arb_cycle(3'b010, 0, 0, '0);
    drain_beats(remaining_beats(), 5);
    idle_r_check();

    // AR backpressure with other requesters still waiting.
    arb_cycle(3'b111, 10, -1, '0);
    drain_beats(remaining_beats(), 0);

    // Fill every route slot, confirm further requests are refused.
    repeat (DEPTH) arb_cycle(onehot(int'($urandom_range(0, NREQ-1))), 0, -1, '0);
    @(negedge clk);
    req_arvalid = 3'b001;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      check("full_no_grant", DW'(req_arready), DW'(0));
      check("full_no_arvalid", DW'(M_AXI_ARVALID), DW'(1'b0));
    end
    @(negedge clk);
    req_arvalid = '0;
    drain_beats(q_len[0] + 1, 0);
    arb_cycle(3'b001, 0, -1, '0);
    drain_beats(remaining_beats(), 0);
    idle_r_check();

    // Reset in the middle of a burst discards routing state.
    arb_cycle(3'b001, 0, 7, '0);
    drain_beats(2, 0);
    @(negedge clk);
    M_AXI_RVALID = 1'b1;
    req_rready   = '1;
    reset        = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_arvalid", DW'(M_AXI_ARVALID), DW'(1'b0));
    check("midrst_arready", DW'(req_arready), DW'(0));
    check("midrst_rvalid", DW'(req_rvalid), DW'(0));
    check("midrst_rready", DW'(M_AXI_RREADY), DW'(1'b0));
    @(negedge clk);
    reset        = 1'b0;
    M_AXI_RVALID = 1'b0;
    req_rready   = '0;
    q_req.delete();
    q_len.delete();
    beat   = 0;
    rr_exp = 0;
    arb_cycle(3'b111, 0, -1, '0);
    drain_beats(remaining_beats(), 0);
    idle_r_check();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
